// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target register block.
//   state_e      : transaction FSM states
//   CmdRwBit     : command bit selecting read (1) or write (0)
//   CmdAddrWidth : width of the address field in the command byte
//   ReadCmd      : value of CmdRwBit that selects a read
package spi_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        DISCARD
    } state_e;

    localparam int   CmdRwBit     = 7;
    localparam int   CmdAddrWidth = 7;
    localparam logic ReadCmd      = 1'b1;

endpackage

// File: rtl/spi_target_frontend.sv
// Pin front end: synchronizes sck/csb/sd into clk_i and turns level changes
// into single-cycle event pulses.
//   clk_i, rst_i               : system clock, synchronous active-high reset
//   spi_sck_i/csb_i/sd_i       : raw SPI pins
//   sck_rise/sck_fall          : internal SCK edge events
//   csb_fall/csb_rise          : internal chip-select edge events
//   csb_level, sd_sync         : levels aligned with the event pulses
// Pin-to-event latency is SyncStages+1 cycles; all outputs share it so sd is
// sampled coherently with its SCK edge.
module spi_target_frontend #(
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_sck_i,
    input  logic spi_csb_i,
    input  logic spi_sd_i,
    output logic sck_rise,
    output logic sck_fall,
    output logic csb_fall,
    output logic csb_rise,
    output logic csb_level,
    output logic sd_sync
);

    logic [SyncStages-1:0] sck_q, csb_q, sd_q;
    logic                  sck_d, csb_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q     <= '0;
            csb_q     <= '1;   // deselected level, so reset creates no csb event
            sd_q      <= '0;
            sck_d     <= 1'b0;
            csb_d     <= 1'b1;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            csb_fall  <= 1'b0;
            csb_rise  <= 1'b0;
            csb_level <= 1'b1;
            sd_sync   <= 1'b0;
        end else begin
            sck_q     <= {sck_q[SyncStages-2:0], spi_sck_i};
            csb_q     <= {csb_q[SyncStages-2:0], spi_csb_i};
            sd_q      <= {sd_q[SyncStages-2:0], spi_sd_i};
            sck_d     <= sck_q[SyncStages-1];
            csb_d     <= csb_q[SyncStages-1];
            sck_rise  <=  sck_q[SyncStages-1] & ~sck_d;
            sck_fall  <= ~sck_q[SyncStages-1] &  sck_d;
            csb_fall  <= ~csb_q[SyncStages-1] &  csb_d;
            csb_rise  <=  csb_q[SyncStages-1] & ~csb_d;
            csb_level <= csb_q[SyncStages-1];
            sd_sync   <= sd_q[SyncStages-1];
        end
    end

endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target exposing NumRegs byte registers. Frame: command byte
// (bit7 read/write, bits6:0 address) then data bytes, auto-increment with wrap.
//   clk_i, rst_i            : system clock, synchronous active-high reset
//   spi_sck/csb/sd_i        : host pins (oversampled in clk_i)
//   spi_sd_o, spi_sd_en_o   : MISO data and output enable
//   regs_o                  : flattened register file, reg k at [8k+7:8k]
//   wr_valid/addr/data_o    : one-cycle pulse per completed host write byte
//   busy_o                  : transaction active
//   oob_o                   : pulse when a command addresses >= NumRegs
module spi_target_regs
    import spi_target_pkg::*;
#(
    parameter int NumRegs    = 16,
    parameter int SyncStages = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       spi_sck_i,
    input  logic                       spi_csb_i,
    input  logic                       spi_sd_i,
    output logic                       spi_sd_o,
    output logic                       spi_sd_en_o,
    output logic [NumRegs*8-1:0]       regs_o,
    output logic                       wr_valid_o,
    output logic [$clog2(NumRegs)-1:0] wr_addr_o,
    output logic [7:0]                 wr_data_o,
    output logic                       busy_o,
    output logic                       oob_o
);

    localparam int AW = $clog2(NumRegs);

    logic sck_rise, sck_fall, csb_fall, csb_rise, csb_level, sd_sync;

    spi_target_frontend #(.SyncStages(SyncStages)) u_frontend (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .spi_sck_i (spi_sck_i),
        .spi_csb_i (spi_csb_i),
        .spi_sd_i  (spi_sd_i),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .csb_fall  (csb_fall),
        .csb_rise  (csb_rise),
        .csb_level (csb_level),
        .sd_sync   (sd_sync)
    );

    state_e                   state, state_n;
    logic [2:0]               bit_cnt;
    logic [CmdAddrWidth-1:0]  shift_in;
    logic [7:0]               in_byte;
    logic [7:0]               shift_out;
    logic [AW-1:0]            addr, addr_inc;
    logic [NumRegs-1:0][7:0]  regs;
    logic                     sck_ok, last_bit, cmd_oob;

    // SCK events count only while selected, and a simultaneous csb release wins.
    assign sck_ok   = ~csb_level & ~csb_rise;
    assign last_bit = (bit_cnt == 3'd7);
    assign in_byte  = {shift_in, sd_sync};
    assign cmd_oob  = int'(in_byte[CmdAddrWidth-1:0]) >= NumRegs;
    assign addr_inc = addr + AW'(1);   // NumRegs is a power of two: wraps to 0
    assign regs_o   = regs;
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (csb_rise) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (csb_fall) state_n = CMD;
                CMD: begin
                    if (sck_ok && sck_rise && last_bit) begin
                        if (cmd_oob)                          state_n = DISCARD;
                        else if (in_byte[CmdRwBit] == ReadCmd) state_n = READ;
                        else                                   state_n = WRITE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt     <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            addr        <= '0;
            regs        <= '0;
            spi_sd_o    <= 1'b0;
            spi_sd_en_o <= 1'b0;
            wr_valid_o  <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            oob_o       <= 1'b0;
        end else begin
            wr_valid_o <= 1'b0;
            oob_o      <= 1'b0;
            if (csb_rise) begin
                spi_sd_en_o <= 1'b0;
                spi_sd_o    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (csb_fall) bit_cnt <= '0;
                    CMD, WRITE: begin
                        if (sck_ok && sck_rise) begin
                            shift_in <= in_byte[CmdAddrWidth-1:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                if (state == CMD) begin
                                    addr      <= in_byte[AW-1:0];
                                    shift_out <= regs[in_byte[AW-1:0]];
                                    oob_o     <= cmd_oob;
                                end else begin
                                    regs[addr] <= in_byte;
                                    wr_valid_o <= 1'b1;
                                    wr_addr_o  <= addr;
                                    wr_data_o  <= in_byte;
                                    addr       <= addr_inc;
                                end
                            end
                        end
                    end
                    READ: begin
                        if (sck_ok && sck_fall) begin
                            bit_cnt     <= bit_cnt + 3'd1;
                            spi_sd_en_o <= 1'b1;
                            // bit_cnt wrapped with the enable already up means a
                            // whole byte went out: snapshot the next register.
                            if (bit_cnt == 3'd0 && spi_sd_en_o) begin
                                spi_sd_o  <= regs[addr_inc][7];
                                shift_out <= {regs[addr_inc][6:0], 1'b0};
                                addr      <= addr_inc;
                            end else begin
                                spi_sd_o  <= shift_out[7];
                                shift_out <= {shift_out[6:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_target_regs.sv
module tb_spi_target_regs;
    localparam int NR = 16;
    localparam int H  = 6;   // SCK half period in clk cycles

    logic            clk = 1'b0, rst = 1'b1, sck = 1'b0, csb = 1'b1, sdi = 1'b0;
    logic            sd_o, sd_en, wr_valid, busy, oob;
    logic [NR*8-1:0] regs;
    logic [3:0]      wr_addr;
    logic [7:0]      wr_data;

    spi_target_regs #(.NumRegs(NR), .SyncStages(2)) dut (
        .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_csb_i(csb), .spi_sd_i(sdi),
        .spi_sd_o(sd_o), .spi_sd_en_o(sd_en), .regs_o(regs), .wr_valid_o(wr_valid),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy), .oob_o(oob)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int wr_n = 0, oob_n = 0, pulse_bad = 0;
    logic [3:0]      log_addr [64];
    logic [7:0]      log_data [64];
    logic [NR*8-1:0] exp_regs = '0;

    // Record every write pulse; the register file must already hold the byte.
    always @(negedge clk) begin
        if (wr_valid) begin
            if (wr_n < 64) begin
                log_addr[wr_n] = wr_addr;
                log_data[wr_n] = wr_data;
            end
            if (regs[wr_addr*8 +: 8] !== wr_data) pulse_bad = pulse_bad + 1;
            wr_n = wr_n + 1;
        end
        if (oob) oob_n = oob_n + 1;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, checks done %0d", n_chk);
        $fatal(1);
    end

    task automatic spi_start();
        csb = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (H) @(negedge clk);
        csb = 1'b1;
        repeat (2*H) @(negedge clk);
    endtask

    // Send the top n bits of tx MSB first; capture MISO and its enable at each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx, output logic [7:0] en);
        rx = '0;
        en = '0;
        for (int i = 7; i > 7 - n; i--) begin
            sdi = tx[i];
            repeat (H) @(negedge clk);
            sck   = 1'b1;
            rx[i] = sd_o;
            en[i] = sd_en;
            repeat (H) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_chk++; if (regs !== '0)        begin n_fail++; $display("FAIL reset_regs: got %h want 0", regs); end
        n_chk++; if (sd_en !== 1'b0)     begin n_fail++; $display("FAIL reset_sd_en: got %b want 0", sd_en); end
        n_chk++; if (sd_o !== 1'b0)      begin n_fail++; $display("FAIL reset_sd_o: got %b want 0", sd_o); end
        n_chk++; if (wr_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        n_chk++; if (wr_addr !== 4'd0)   begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        n_chk++; if (wr_data !== 8'd0)   begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (oob !== 1'b0)       begin n_fail++; $display("FAIL reset_oob: got %b want 0", oob); end
    endtask

    task automatic test_write();
        logic [7:0] rx, en0, en1, en2;
        int b;
        b = wr_n;
        spi_start();
        spi_bits(8'h03, 8, rx, en0);
        spi_bits(8'hA5, 8, rx, en1);
        spi_bits(8'h5A, 8, rx, en2);
        spi_end();
        exp_regs[3*8 +: 8] = 8'hA5;
        exp_regs[4*8 +: 8] = 8'h5A;
        n_chk++; if (wr_n - b !== 2)          begin n_fail++; $display("FAIL write_count: got %0d want 2", wr_n - b); end
        n_chk++; if (log_addr[b] !== 4'd3)    begin n_fail++; $display("FAIL write_addr0: got %h want 3", log_addr[b]); end
        n_chk++; if (log_data[b] !== 8'hA5)   begin n_fail++; $display("FAIL write_data0: got %h want a5", log_data[b]); end
        n_chk++; if (log_addr[b+1] !== 4'd4)  begin n_fail++; $display("FAIL write_addr1: got %h want 4", log_addr[b+1]); end
        n_chk++; if (log_data[b+1] !== 8'h5A) begin n_fail++; $display("FAIL write_data1: got %h want 5a", log_data[b+1]); end
        n_chk++; if (regs !== exp_regs)       begin n_fail++; $display("FAIL write_regs: got %h want %h", regs, exp_regs); end
        n_chk++; if ((en0 | en1 | en2) !== 8'h00) begin n_fail++; $display("FAIL write_sd_en: got %h want 00", en0 | en1 | en2); end
        n_chk++; if (pulse_bad !== 0)         begin n_fail++; $display("FAIL write_regs_at_pulse: got %0d want 0", pulse_bad); end
    endtask

    task automatic test_read();
        logic [7:0] rx0, rx1, en0, en1, en2, d;
        logic busy_mid;
        int b;
        // Preload through a wrapping write: 15 <- 3C, 0 <- C3.
        b = wr_n;
        spi_start();
        spi_bits(8'h0F, 8, d, en0);
        spi_bits(8'h3C, 8, d, en0);
        spi_bits(8'hC3, 8, d, en0);
        spi_end();
        exp_regs[15*8 +: 8] = 8'h3C;
        exp_regs[0 +: 8]    = 8'hC3;
        n_chk++; if (log_addr[b+1] !== 4'd0) begin n_fail++; $display("FAIL write_wrap_addr: got %h want 0", log_addr[b+1]); end
        n_chk++; if (regs !== exp_regs)      begin n_fail++; $display("FAIL preload_regs: got %h want %h", regs, exp_regs); end
        spi_start();
        spi_bits(8'h8F, 8, d, en0);
        busy_mid = busy;
        spi_bits(8'h00, 8, rx0, en1);
        spi_bits(8'h00, 8, rx1, en2);
        spi_end();
        n_chk++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b want 1", busy_mid); end
        n_chk++; if (rx0 !== 8'h3C)     begin n_fail++; $display("FAIL read_byte0: got %h want 3c", rx0); end
        n_chk++; if (rx1 !== 8'hC3)     begin n_fail++; $display("FAIL read_byte1_wrap: got %h want c3", rx1); end
        n_chk++; if (en0 !== 8'h00)     begin n_fail++; $display("FAIL read_en_cmd: got %h want 00", en0); end
        n_chk++; if ((en1 & en2) !== 8'hFF) begin n_fail++; $display("FAIL read_en_data: got %h want ff", en1 & en2); end
        n_chk++; if (sd_en !== 1'b0)    begin n_fail++; $display("FAIL read_en_after: got %b want 0", sd_en); end
        n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL read_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_oob();
        logic [7:0] rx, en;
        int b, o;
        b = wr_n;
        o = oob_n;
        spi_start();
        spi_bits(8'h20, 8, rx, en);
        spi_bits(8'hFF, 8, rx, en);
        spi_end();
        n_chk++; if (oob_n - o !== 1)   begin n_fail++; $display("FAIL oob_pulses: got %0d want 1", oob_n - o); end
        n_chk++; if (wr_n - b !== 0)    begin n_fail++; $display("FAIL oob_writes: got %0d want 0", wr_n - b); end
        n_chk++; if (regs !== exp_regs) begin n_fail++; $display("FAIL oob_regs: got %h want %h", regs, exp_regs); end
        n_chk++; if (en !== 8'h00)      begin n_fail++; $display("FAIL oob_sd_en: got %h want 00", en); end
    endtask

    task automatic test_abort();
        logic [7:0] rx, en;
        int b;
        b = wr_n;
        spi_start();
        spi_bits(8'h05, 8, rx, en);
        spi_bits(8'hFF, 5, rx, en);
        spi_end();
        n_chk++; if (wr_n - b !== 0)    begin n_fail++; $display("FAIL abort_writes: got %0d want 0", wr_n - b); end
        n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_chk++; if (regs !== exp_regs) begin n_fail++; $display("FAIL abort_regs: got %h want %h", regs, exp_regs); end
        spi_start();
        spi_bits(8'h05, 8, rx, en);
        spi_bits(8'h11, 8, rx, en);
        spi_end();
        exp_regs[5*8 +: 8] = 8'h11;
        n_chk++; if (wr_n - b !== 1)       begin n_fail++; $display("FAIL abort_next_count: got %0d want 1", wr_n - b); end
        n_chk++; if (log_addr[b] !== 4'd5) begin n_fail++; $display("FAIL abort_next_addr: got %h want 5", log_addr[b]); end
        n_chk++; if (regs !== exp_regs)    begin n_fail++; $display("FAIL abort_next_regs: got %h want %h", regs, exp_regs); end
    endtask

    task automatic test_noise();
        logic [7:0] rx, en;
        int b, busy_hits;
        b = wr_n;
        busy_hits = 0;
        for (int i = 0; i < 20; i++) begin
            sck = ~sck;
            sdi = ~sdi;
            repeat (H) @(negedge clk);
            if (busy) busy_hits++;
        end
        n_chk++; if (busy_hits !== 0) begin n_fail++; $display("FAIL noise_busy: got %0d busy samples want 0", busy_hits); end
        n_chk++; if (wr_n - b !== 0)   begin n_fail++; $display("FAIL noise_writes: got %0d want 0", wr_n - b); end
        // Last data bit's SCK rise coincides with csb release: no write.
        spi_start();
        spi_bits(8'h07, 8, rx, en);
        spi_bits(8'hFF, 7, rx, en);
        sdi = 1'b1;
        repeat (H) @(negedge clk);
        sck = 1'b1;
        csb = 1'b1;
        repeat (2*H) @(negedge clk);
        sck = 1'b0;
        repeat (2*H) @(negedge clk);
        n_chk++; if (wr_n - b !== 0)    begin n_fail++; $display("FAIL race_writes: got %0d want 0", wr_n - b); end
        n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL race_busy: got %b want 0", busy); end
        n_chk++; if (regs !== exp_regs) begin n_fail++; $display("FAIL race_regs: got %h want %h", regs, exp_regs); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx, en;
        spi_start();
        spi_bits(8'h83, 8, rx, en);
        spi_bits(8'h00, 2, rx, en);
        sdi = 1'b0;
        repeat (H) @(negedge clk);
        sck = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (sd_en !== 1'b1) begin n_fail++; $display("FAIL midread_en_before: got %b want 1", sd_en); end
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (sd_en !== 1'b0) begin n_fail++; $display("FAIL midread_sd_en: got %b want 0", sd_en); end
        n_chk++; if (regs !== '0)    begin n_fail++; $display("FAIL midread_regs: got %h want 0", regs); end
        n_chk++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL midread_busy: got %b want 0", busy); end
        rst = 1'b0;
        sck = 1'b0;
        csb = 1'b1;
        exp_regs = '0;
        repeat (2*H) @(negedge clk);
        n_chk++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        test_write();
        test_read();
        test_oob();
        test_abort();
        test_noise();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
